gshare_branch_predictor: RTL and testbench

- Dynamic next-PC predictor for the 5-stage pipeline. It replaces the static PC+4 fetch prediction.
- Looks up the fetch PC combinationally in a direct-mapped BTB and a gshare table of 2-bit counters, then drives the predicted next PC into the next-PC mux in IF.
- Trained one instruction per cycle from EX with the resolved outcome of each valid (non-squashed) control instruction.
- The existing control-hazard compare of resolved PC vs IF/ID PC still detects mispredicts; this block does not flush.

---
 rtl/gshare_branch_predictor_if.sv | 31 +++
 rtl/gshare_branch_predictor.sv | 80 ++++++++
 tb/tb_gshare_branch_predictor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup and EX-side training signals of the gshare next-PC predictor.
// The pipeline drives through master; the predictor consumes through slave.
interface gshare_branch_predictor_if;
    logic [31:0] current_pc;
    logic [31:0] predicted_pc;
    logic        predicted_taken;
    logic        update_enable;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;

    modport master (
        output current_pc,
        output update_enable,
        output update_pc,
        output update_taken,
        output update_target,
        input  predicted_pc,
        input  predicted_taken
    );

    modport slave (
        input  current_pc,
        input  update_enable,
        input  update_pc,
        input  update_taken,
        input  update_target,
        output predicted_pc,
        output predicted_taken
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare next-PC predictor: direct-mapped BTB plus 2-bit counter table indexed by pc^ghr.
// Lookup is combinational (zero latency); training takes effect one cycle later; no backpressure.
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int GHR_BITS   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    gshare_branch_predictor_if.slave bp
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
    } btb_entry_t;

    btb_entry_t          btb [ENTRIES];
    logic [1:0]          bht [ENTRIES];
    logic [GHR_BITS-1:0] ghr;

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] bidx;
    logic [INDEX_BITS-1:0] gidx;
    logic [INDEX_BITS-1:0] ubidx;
    logic [INDEX_BITS-1:0] ugidx;
    logic                  hit;
    logic [1:0]            cnt_cur;
    logic [1:0]            cnt_next;
    logic [GHR_BITS-1:0]   ghr_next;
    logic                  unused_pc_low;

    // Instructions are word aligned, so the low PC bits never select an entry.
    assign unused_pc_low = &{1'b0, bp.update_pc[1:0]};

    assign ghr_ext = INDEX_BITS'(ghr);
    assign bidx    = bp.current_pc[INDEX_BITS+1:2];
    assign gidx    = bidx ^ ghr_ext;
    assign ubidx   = bp.update_pc[INDEX_BITS+1:2];
    assign ugidx   = ubidx ^ ghr_ext;

    assign hit = btb[bidx].valid && (btb[bidx].tag == bp.current_pc[31:INDEX_BITS+2]);

    assign bp.predicted_taken = hit && bht[gidx][1];
    assign bp.predicted_pc    = bp.predicted_taken ? btb[bidx].target : bp.current_pc + 32'd4;

    always_comb begin
        cnt_cur  = bht[ugidx];
        cnt_next = cnt_cur;
        if (bp.update_taken) begin
            if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
        end
    end

    // Truncating the concatenation keeps the newest outcomes and also covers GHR_BITS == 1.
    assign ghr_next = GHR_BITS'({ghr, bp.update_taken});

    // History is non-speculative: it only moves when EX resolves a control instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                bht[i]       <= 2'b01;
            end
            ghr <= '0;
        end else if (bp.update_enable) begin
            bht[ugidx] <= cnt_next;
            if (bp.update_taken) begin
                btb[ubidx] <= '{valid:  1'b1,
                                tag:    bp.update_pc[31:INDEX_BITS+2],
                                target: bp.update_target};
            end
            ghr <= ghr_next;
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    gshare_branch_predictor_if bp ();

    gshare_branch_predictor #(
        .INDEX_BITS (5),
        .GHR_BITS   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bp.update_enable = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bp.update_pc     = pc;
        bp.update_taken  = taken;
        bp.update_target = target;
        bp.update_enable = 1'b1;
        tick();
        bp.update_enable = 1'b0;
    endtask

    // Five not-taken updates at 0x84 walk ghr 00001 back to 00000 without touching BHT[0x10].
    task automatic drain_ghr_84();
        for (int i = 0; i < 5; i++) do_update(32'h84, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        bp.current_pc = 32'h40;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", bp.predicted_pc, 32'h44);
        end
        checks++;
        if (bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken: got %b expected 0", bp.predicted_taken);
        end
        bp.current_pc = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_wrap: got %h expected 00000000", bp.predicted_pc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        do_update(32'h40, 1'b0, 32'h0);
        do_update(32'h40, 1'b0, 32'h0);
        bp.current_pc = 32'h40;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44) begin
            errors++;
            $display("FAIL sat_nt_pc: got %h expected %h", bp.predicted_pc, 32'h44);
        end
        do_update(32'h40, 1'b1, 32'h100);
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL sat_gidx11: got %h/%b expected 00000044/0", bp.predicted_pc, bp.predicted_taken);
        end
        // Back to ghr=0: BHT[0x10] must be 01 (not wrapped to 11), so still not taken.
        drain_ghr_84();
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL sat_floor: got %h/%b expected 00000044/0", bp.predicted_pc, bp.predicted_taken);
        end
    endtask

    task automatic test_taken();
        do_reset();
        do_update(32'h40, 1'b1, 32'h100);
        drain_ghr_84();
        bp.current_pc = 32'h40;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h100) begin
            errors++;
            $display("FAIL taken_pc: got %h expected %h", bp.predicted_pc, 32'h100);
        end
        checks++;
        if (bp.predicted_taken !== 1'b1) begin
            errors++;
            $display("FAIL taken_flag: got %b expected 1", bp.predicted_taken);
        end
        bp.current_pc = 32'h44;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h48 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL taken_other_entry: got %h/%b expected 00000048/0", bp.predicted_pc, bp.predicted_taken);
        end
    endtask

    // Continues from the state left by test_taken.
    task automatic test_tag_mismatch();
        bp.current_pc = 32'hC0;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'hC4 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL tag_miss_c0: got %h/%b expected 000000c4/0", bp.predicted_pc, bp.predicted_taken);
        end
        do_update(32'hC0, 1'b1, 32'h300);
        bp.current_pc = 32'h40;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL tag_replaced_40: got %h/%b expected 00000044/0", bp.predicted_pc, bp.predicted_taken);
        end
        // ghr back to 0 selects BHT[0x10]=11, so the new entry's target is predicted.
        drain_ghr_84();
        bp.current_pc = 32'hC0;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h300 || bp.predicted_taken !== 1'b1) begin
            errors++;
            $display("FAIL tag_new_c0: got %h/%b expected 00000300/1", bp.predicted_pc, bp.predicted_taken);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        // Train BHT[0x11]=10, then return ghr to 0 via not-taken updates at 0x88.
        do_update(32'h44, 1'b1, 32'h200);
        for (int i = 0; i < 5; i++) do_update(32'h88, 1'b0, 32'h0);
        bp.current_pc    = 32'h40;
        bp.update_pc     = 32'h40;
        bp.update_taken  = 1'b1;
        bp.update_target = 32'h100;
        bp.update_enable = 1'b1;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_old: got %h/%b expected 00000044/0", bp.predicted_pc, bp.predicted_taken);
        end
        tick();
        bp.update_enable = 1'b0;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h100 || bp.predicted_taken !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_new: got %h/%b expected 00000100/1", bp.predicted_pc, bp.predicted_taken);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_update(32'h40, 1'b1, 32'h100);
        drain_ghr_84();
        bp.current_pc = 32'h40;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h100) begin
            errors++;
            $display("FAIL mid_setup: got %h expected 00000100", bp.predicted_pc);
        end
        reset            = 1'b1;
        bp.update_pc     = 32'h40;
        bp.update_taken  = 1'b1;
        bp.update_target = 32'h100;
        bp.update_enable = 1'b1;
        tick();
        reset            = 1'b0;
        bp.update_enable = 1'b0;
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h44 || bp.predicted_taken !== 1'b0) begin
            errors++;
            $display("FAIL mid_discard: got %h/%b expected 00000044/0", bp.predicted_pc, bp.predicted_taken);
        end
        // Replaying the taken sequence only lands on BHT[0x10] if ghr really restarted at 0.
        do_update(32'h40, 1'b1, 32'h100);
        drain_ghr_84();
        #1;
        checks++;
        if (bp.predicted_pc !== 32'h100 || bp.predicted_taken !== 1'b1) begin
            errors++;
            $display("FAIL mid_ghr_zero: got %h/%b expected 00000100/1", bp.predicted_pc, bp.predicted_taken);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b0;
        bp.current_pc    = 32'h0;
        bp.update_enable = 1'b0;
        bp.update_pc     = 32'h0;
        bp.update_taken  = 1'b0;
        bp.update_target = 32'h0;
        test_reset();
        test_saturation();
        test_taken();
        test_tag_mismatch();
        test_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
